// File: rtl/i2c_slave_bit_shift.sv
`timescale 1ns/1ps
// I2C target byte engine: filtered START/STOP decode, address match with ACK,
// write-byte reception and read-byte transmission on an open-drain SDA line.
module i2c_slave_bit_shift #(
  parameter logic [6:0]  DEV_ADDR   = 7'h50,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic [7:0] Rx_DATA,
  output logic       Rx_Valid,
  input  logic [7:0] Tx_DATA,
  output logic       Tx_Req,
  output logic       Rw_o,
  output logic       Addr_Match,
  output logic       Stop_Det,
  output logic       Busy
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  // Line index 0 is SCL, index 1 is SDA.
  logic [1:0]    meta, sync, filt, filt_q;
  logic [CW-1:0] fcnt [2];

  state_t     state, state_n;
  logic [3:0] bit_cnt, cnt_n;
  logic [6:0] shift, shift_n;
  logic       sda_oe, sda_oe_n;
  logic [7:0] rx_data_n, byte_in;
  logic       rw_n, busy_n, rx_valid_n, tx_req_n, addr_match_n, stop_det_n;

  logic scl_rise, scl_fall, start_cond, stop_cond;

  assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

  // NOTE: synchronizer and filter stages reset to the idle bus level (high),
  // so reset release does not manufacture a false edge or START.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      meta   <= '1;
      sync   <= '1;
      filt   <= '1;
      filt_q <= '1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      meta   <= {i2c_sdat, i2c_sclk};
      sync   <= meta;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i] <= sync[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_rise   =  filt[0] & ~filt_q[0];
  assign scl_fall   = ~filt[0] &  filt_q[0];
  assign start_cond =  filt[0] &  filt_q[0] &  filt_q[1] & ~filt[1];
  assign stop_cond  =  filt[0] &  filt_q[0] & ~filt_q[1] &  filt[1];

  // NOTE: state and outputs update with non-blocking assignments only, so
  // every register in this block sees the pre-edge values of the others.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      sda_oe     <= 1'b0;
      Rx_DATA    <= '0;
      Rx_Valid   <= 1'b0;
      Tx_Req     <= 1'b0;
      Rw_o       <= 1'b0;
      Addr_Match <= 1'b0;
      Stop_Det   <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= cnt_n;
      shift      <= shift_n;
      sda_oe     <= sda_oe_n;
      Rx_DATA    <= rx_data_n;
      Rx_Valid   <= rx_valid_n;
      Tx_Req     <= tx_req_n;
      Rw_o       <= rw_n;
      Addr_Match <= addr_match_n;
      Stop_Det   <= stop_det_n;
      Busy       <= busy_n;
    end
  end

  // NOTE: every signal gets a default before the case, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n      = state;
    cnt_n        = bit_cnt;
    shift_n      = shift;
    sda_oe_n     = sda_oe;
    rx_data_n    = Rx_DATA;
    rw_n         = Rw_o;
    busy_n       = Busy;
    rx_valid_n   = 1'b0;
    tx_req_n     = 1'b0;
    addr_match_n = 1'b0;
    stop_det_n   = 1'b0;
    byte_in      = {shift, filt[1]};

    if (stop_cond) begin
      state_n    = IDLE;
      sda_oe_n   = 1'b0;
      busy_n     = 1'b0;
      cnt_n      = '0;
      stop_det_n = 1'b1;
    end else if (start_cond) begin
      state_n  = ADDR;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
      cnt_n    = '0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_n = byte_in[6:0];
            cnt_n   = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              cnt_n = '0;
              if (byte_in[7:1] == DEV_ADDR) begin
                rw_n         = byte_in[0];
                addr_match_n = 1'b1;
                busy_n       = 1'b1;
                tx_req_n     = byte_in[0];
                state_n      = ADDR_ACK;
              end else begin
                state_n = IGNORE;
              end
            end
          end
        end

        // Shared ACK slot: count 0 -> drive on fall, 1 -> 9th rise seen,
        // 2 -> next fall ends the slot.
        ADDR_ACK, WR_ACK: begin
          if (scl_fall && bit_cnt == 4'd0) begin
            sda_oe_n = 1'b1;
            cnt_n    = 4'd1;
          end else if (scl_rise && bit_cnt == 4'd1) begin
            cnt_n = 4'd2;
          end else if (scl_fall && bit_cnt == 4'd2) begin
            cnt_n = '0;
            if (state == WR_ACK || !Rw_o) begin
              sda_oe_n = 1'b0;
              state_n  = WR_DATA;
            end else begin
              shift_n  = Tx_DATA[6:0];
              sda_oe_n = ~Tx_DATA[7];
              state_n  = RD_DATA;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift_n = byte_in[6:0];
            cnt_n   = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              rx_data_n  = byte_in;
              rx_valid_n = 1'b1;
              cnt_n      = '0;
              state_n    = WR_ACK;
            end
          end
        end

        RD_DATA: begin
          if (scl_rise) begin
            cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n = 1'b0;
              cnt_n    = '0;
              state_n  = RD_ACK;
            end else begin
              sda_oe_n = ~shift[6];
              shift_n  = {shift[5:0], 1'b0};
            end
          end
        end

        RD_ACK: begin
          if (scl_rise && bit_cnt == 4'd0) begin
            if (!filt[1]) begin
              tx_req_n = 1'b1;
              cnt_n    = 4'd1;
            end else begin
              busy_n  = 1'b0;
              state_n = IGNORE;
            end
          end else if (scl_fall && bit_cnt == 4'd1) begin
            shift_n  = Tx_DATA[6:0];
            sda_oe_n = ~Tx_DATA[7];
            cnt_n    = '0;
            state_n  = RD_DATA;
          end
        end

        IDLE, IGNORE: sda_oe_n = 1'b0;

        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_bit_shift.sv
`timescale 1ns/1ps
// Bench for i2c_slave_bit_shift: bit-banged I2C master with a pulled-up SDA,
// a pulse monitor, and a transaction-level model of the target's responses.
module tb_i2c_slave_bit_shift;

  localparam int         Q    = 100;   // quarter SCL period in ns (SCL = 40 Clk)
  localparam logic [6:0] ADDR = 7'h50;

  logic       Clk = 1'b0, Rst_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
  wire        i2c_sdat;
  logic [7:0] Rx_DATA;
  logic [7:0] Tx_DATA = 8'h00;
  logic       Rx_Valid, Tx_Req, Rw_o, Addr_Match, Stop_Det, Busy;

  int total = 0, bad = 0;
  int n_addr = 0, n_rx = 0, n_txreq = 0, n_stop = 0, n_dut_low = 0;
  logic [7:0] rx_log [$];

  assign i2c_sdat = m_sda ? 1'bz : 1'b0;
  pullup (i2c_sdat);

  always #5 Clk = ~Clk;

  i2c_slave_bit_shift #(.DEV_ADDR(ADDR), .FILTER_LEN(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .i2c_sclk(m_scl), .i2c_sdat(i2c_sdat),
    .Rx_DATA(Rx_DATA), .Rx_Valid(Rx_Valid), .Tx_DATA(Tx_DATA), .Tx_Req(Tx_Req),
    .Rw_o(Rw_o), .Addr_Match(Addr_Match), .Stop_Det(Stop_Det), .Busy(Busy)
  );

  always @(negedge Clk) begin
    if (Addr_Match) n_addr++;
    if (Tx_Req) n_txreq++;
    if (Stop_Det) n_stop++;
    if (Rx_Valid) begin
      n_rx++;
      rx_log.push_back(Rx_DATA);
    end
    if (m_sda && i2c_sdat === 1'b0) n_dut_low++;
  end

  // ---------------- bus primitives (all edges land on Clk negedges) ----------
  task automatic bus_start();
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #Q;
  endtask

  // glitch: 1 = 10 ns SCL pulse while low, 2 = 10 ns SDA flip while SCL high
  task automatic put_bit(input logic b, input int glitch);
    m_sda = b;
    if (glitch == 1) begin
      #(Q/2); m_scl = 1'b1; #10; m_scl = 1'b0; #(Q/2 - 10);
    end else #Q;
    m_scl = 1'b1;
    if (glitch == 2) begin
      #(Q/2); m_sda = ~b; #10; m_sda = b; #(Q/2 - 10);
    end else #Q;
    #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; b = i2c_sdat; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i], 0);
    get_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack,
                           input logic [7:0] next_tx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    Tx_DATA = next_tx;
    put_bit(master_ack, 0);
  endtask

  // ---------------- scenarios ------------------------------------------------
  task automatic test_reset();
    Rst_n = 1'b0;
    #(2*Q);
    total++;
    if ({Rx_DATA, Rx_Valid, Tx_Req, Rw_o, Addr_Match, Stop_Det, Busy} !== 14'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {Rx_DATA, Rx_Valid, Tx_Req, Rw_o, Addr_Match, Stop_Det, Busy});
    end
    total++;
    if (i2c_sdat !== 1'b1) begin
      bad++; $display("FAIL reset_sda: got %b want 1", i2c_sdat);
    end
    Rst_n = 1'b1;
    #(2*Q);
  endtask

  task automatic test_write();
    int a0, r0, s0;
    logic ack;
    logic [7:0] d;
    a0 = n_addr; r0 = n_rx; s0 = n_stop;
    bus_start();
    write_byte({ADDR, 1'b0}, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL wr_addr_ack: got %b want 0", ack); end
    total++;
    if (Busy !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", Busy); end
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 8'hA5 : 8'h3C;
      write_byte(d, ack);
      total++;
      if (ack !== 1'b0) begin bad++; $display("FAIL wr_data_ack%0d: got %b want 0", k, ack); end
    end
    bus_stop();
    #Q;
    total++;
    if (n_addr - a0 != 1) begin bad++; $display("FAIL wr_addr_match: got %0d want 1", n_addr - a0); end
    total++;
    if (n_rx - r0 != 2) begin bad++; $display("FAIL wr_rx_count: got %0d want 2", n_rx - r0); end
    total++;
    if (rx_log.size() < r0 + 2 || rx_log[r0] !== 8'hA5 || rx_log[r0+1] !== 8'h3C) begin
      bad++; $display("FAIL wr_rx_data: got %0d bytes want A5 3C", rx_log.size() - r0);
    end
    total++;
    if (n_stop - s0 != 1) begin bad++; $display("FAIL wr_stop: got %0d want 1", n_stop - s0); end
    total++;
    if (Busy !== 1'b0) begin bad++; $display("FAIL wr_busy_after_stop: got %b want 0", Busy); end
  endtask

  task automatic test_wrong_addr();
    int a0, r0, t0, s0, l0;
    logic ack;
    logic [7:0] addr_byte;
    for (int k = 0; k < 2; k++) begin
      addr_byte = (k == 0) ? 8'hA2 : 8'h00;   // 0x51 write, then general call
      a0 = n_addr; r0 = n_rx; t0 = n_txreq; s0 = n_stop; l0 = n_dut_low;
      bus_start();
      write_byte(addr_byte, ack);
      total++;
      if (ack !== 1'b1) begin bad++; $display("FAIL nack_addr%0d: got %b want 1", k, ack); end
      write_byte(8'hFF, ack);
      total++;
      if (ack !== 1'b1) begin bad++; $display("FAIL nack_data%0d: got %b want 1", k, ack); end
      bus_stop();
      #Q;
      total++;
      if (n_dut_low != l0) begin bad++; $display("FAIL nack_sda_driven%0d: got %0d want 0", k, n_dut_low - l0); end
      total++;
      if (n_addr != a0 || n_rx != r0 || n_txreq != t0) begin
        bad++; $display("FAIL nack_pulses%0d: got %0d/%0d/%0d want 0/0/0", k, n_addr - a0, n_rx - r0, n_txreq - t0);
      end
      total++;
      if (n_stop - s0 != 1) begin bad++; $display("FAIL nack_stop%0d: got %0d want 1", k, n_stop - s0); end
    end
  endtask

  task automatic test_read();
    int t0, l0;
    logic ack;
    logic [7:0] d;
    t0 = n_txreq;
    Tx_DATA = 8'h96;
    bus_start();
    write_byte({ADDR, 1'b1}, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
    total++;
    if (Rw_o !== 1'b1) begin bad++; $display("FAIL rd_rw: got %b want 1", Rw_o); end
    read_byte(d, 1'b0, 8'hF0);
    total++;
    if (d !== 8'h96) begin bad++; $display("FAIL rd_byte0: got %h want 96", d); end
    read_byte(d, 1'b1, 8'h00);
    total++;
    if (d !== 8'hF0) begin bad++; $display("FAIL rd_byte1: got %h want f0", d); end
    total++;
    if (Busy !== 1'b0) begin bad++; $display("FAIL rd_busy_after_nack: got %b want 0", Busy); end
    l0 = n_dut_low;
    bus_stop();
    #Q;
    total++;
    if (n_dut_low != l0) begin bad++; $display("FAIL rd_sda_after_nack: got %0d want 0", n_dut_low - l0); end
    total++;
    if (n_txreq - t0 != 2) begin bad++; $display("FAIL rd_tx_req: got %0d want 2", n_txreq - t0); end
  endtask

  task automatic test_repeated_start();
    int a0, r0;
    logic ack;
    logic [7:0] d, tx;
    a0 = n_addr; r0 = n_rx;
    tx = 8'($urandom);
    bus_start();
    write_byte({ADDR, 1'b0}, ack);
    for (int i = 0; i < 4; i++) put_bit(1'($urandom), 0);
    Tx_DATA = tx;
    bus_start();
    write_byte({ADDR, 1'b1}, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL rs_addr_ack: got %b want 0", ack); end
    read_byte(d, 1'b1, 8'h00);
    bus_stop();
    #Q;
    total++;
    if (d !== tx) begin bad++; $display("FAIL rs_read: got %h want %h", d, tx); end
    total++;
    if (n_rx != r0) begin bad++; $display("FAIL rs_partial_rx: got %0d want 0", n_rx - r0); end
    total++;
    if (n_addr - a0 != 2) begin bad++; $display("FAIL rs_addr_match: got %0d want 2", n_addr - a0); end
    total++;
    if (Rw_o !== 1'b1) begin bad++; $display("FAIL rs_rw: got %b want 1", Rw_o); end
  endtask

  task automatic test_reset_mid_read();
    int r0;
    logic ack, b;
    logic [7:0] d;
    Tx_DATA = 8'h00;
    bus_start();
    write_byte({ADDR, 1'b1}, ack);
    for (int i = 0; i < 3; i++) get_bit(b);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #(Q/2);
    total++;
    if (i2c_sdat !== 1'b0) begin bad++; $display("FAIL rst_pre_drive: got %b want 0", i2c_sdat); end
    Rst_n = 1'b0;
    #1;
    total++;
    if (i2c_sdat !== 1'b1) begin bad++; $display("FAIL rst_sda_release: got %b want 1", i2c_sdat); end
    total++;
    if ({Rx_DATA, Rx_Valid, Tx_Req, Rw_o, Addr_Match, Stop_Det, Busy} !== 14'h0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got %h want 0",
               {Rx_DATA, Rx_Valid, Tx_Req, Rw_o, Addr_Match, Stop_Det, Busy});
    end
    #(Q/2 - 1); m_scl = 1'b0; #Q;
    Rst_n = 1'b1;
    #Q;
    bus_stop();
    #Q;
    r0 = n_rx;
    d = 8'($urandom);
    bus_start();
    write_byte({ADDR, 1'b0}, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL rst_after_ack: got %b want 0", ack); end
    write_byte(d, ack);
    bus_stop();
    #Q;
    total++;
    if (rx_log.size() != r0 + 1 || rx_log[r0] !== d) begin
      bad++; $display("FAIL rst_after_rx: got %0d bytes want 1 byte %h", rx_log.size() - r0, d);
    end
  endtask

  task automatic test_glitch();
    int a0, r0, s0;
    logic ack;
    logic [7:0] bytes [2];
    bytes[0] = {ADDR, 1'b0};
    bytes[1] = 8'h5A;
    a0 = n_addr; r0 = n_rx; s0 = n_stop;
    bus_start();
    for (int k = 0; k < 2; k++) begin
      for (int i = 7; i >= 0; i--)
        put_bit(bytes[k][i], (i == 5 || i == 3) ? 1 : ((i == 2 || i == 6) ? 2 : 0));
      get_bit(ack);
      total++;
      if (ack !== 1'b0) begin bad++; $display("FAIL glitch_ack%0d: got %b want 0", k, ack); end
    end
    total++;
    if (n_stop != s0) begin bad++; $display("FAIL glitch_false_stop: got %0d want 0", n_stop - s0); end
    bus_stop();
    #Q;
    total++;
    if (rx_log.size() != r0 + 1 || rx_log[r0] !== 8'h5A) begin
      bad++; $display("FAIL glitch_rx: got %0d bytes want 1 byte 5a", rx_log.size() - r0);
    end
    total++;
    if (n_addr - a0 != 1) begin bad++; $display("FAIL glitch_addr: got %0d want 1", n_addr - a0); end
  endtask

  // Back-to-back random transactions against a transaction-level model.
  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [6:0] a;
      logic       rw, match, ack;
      int         nb, a0, r0, t0;
      logic [7:0] tx [$];
      logic [7:0] exp_rx [$];
      logic [7:0] d;
      a     = ($urandom_range(0, 2) != 0) ? ADDR : 7'($urandom);
      rw    = 1'($urandom);
      nb    = $urandom_range(1, 3);
      match = (a == ADDR);
      a0 = n_addr; r0 = n_rx; t0 = n_txreq;
      for (int i = 0; i < nb; i++) tx.push_back(8'($urandom));
      Tx_DATA = tx[0];
      bus_start();
      write_byte({a, rw}, ack);
      total++;
      if (ack !== !match) begin bad++; $display("FAIL rnd%0d_addr_ack: got %b want %b", t, ack, !match); end
      for (int i = 0; i < nb; i++) begin
        if (rw) begin
          read_byte(d, (i == nb - 1), (i + 1 < nb) ? tx[i+1] : 8'h00);
          total++;
          if (d !== (match ? tx[i] : 8'hFF)) begin
            bad++; $display("FAIL rnd%0d_rd%0d: got %h want %h", t, i, d, match ? tx[i] : 8'hFF);
          end
        end else begin
          write_byte(tx[i], ack);
          if (match) exp_rx.push_back(tx[i]);
          total++;
          if (ack !== !match) begin bad++; $display("FAIL rnd%0d_wr_ack%0d: got %b want %b", t, i, ack, !match); end
        end
      end
      bus_stop();
      #Q;
      total++;
      if (n_addr - a0 != int'(match) || n_txreq - t0 != ((match && rw) ? nb : 0)) begin
        bad++; $display("FAIL rnd%0d_pulses: got am=%0d tr=%0d want am=%0d tr=%0d", t,
                        n_addr - a0, n_txreq - t0, int'(match), (match && rw) ? nb : 0);
      end
      total++;
      if (n_rx - r0 != exp_rx.size()) begin
        bad++; $display("FAIL rnd%0d_rx_count: got %0d want %0d", t, n_rx - r0, exp_rx.size());
      end else begin
        for (int i = 0; i < exp_rx.size(); i++) begin
          total++;
          if (rx_log[r0 + i] !== exp_rx[i]) begin
            bad++; $display("FAIL rnd%0d_rx%0d: got %h want %h", t, i, rx_log[r0 + i], exp_rx[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_repeated_start();
    test_reset_mid_read();
    test_glitch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
